// File: rtl/grp_dist_arb_pkg.sv
// Shared definitions for the group-buffer distributor: bank encoding,
// default geometry, swap-control states and a small popcount helper.
package grp_dist_arb_pkg;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  localparam int DEF_N  = 5;
  localparam int DEF_DW = 12;
  localparam int DEF_AW = 10;
  localparam int DEF_CW = 8;

  // Deferred-swap controller states
  typedef enum logic [1:0] {
    SW_IDLE = 2'b00,
    SW_PEND = 2'b01
  } sw_state_e;

  // Number of set bits in an 8-bit vector (channel count is at most 8)
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/grp_dist_arb_rr_arbiter_n.sv
// Round-robin arbiter: one-hot registered grant, held while the owner's
// busy stays high, cleared for one idle cycle before the next award.
module rr_arbiter_n
  import grp_dist_arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  busy,
  input  logic          inhibit,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] owner_idx,
  output logic          owner_vld
);

  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] cand_s;
  logic          found_s;

  // Next grant: hold while owner busy, release to zero, else search upward from last owner
  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    found_s = 1'b0;
    cand_s  = '0;
    if (grant_q != '0) begin
      if (busy[last_q]) begin
        grant_d = grant_q;
      end else begin
        grant_d = '0;
      end
    end else if (inhibit) begin
      grant_d = '0;
    end else begin
      for (int i = 1; i <= N; i++) begin
        cand_s = IW'((int'(last_q) + i) % N);
        if (!found_s && busy[cand_s]) begin
          found_s         = 1'b1;
          grant_d         = '0;
          grant_d[cand_s] = 1'b1;
          last_d          = cand_s;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // Grant and last-owner pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q <= '0;
      last_q  <= IW'(N - 1);
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign grant     = grant_q;
  assign owner_idx = last_q;
  assign owner_vld = |grant_q;

endmodule

// File: rtl/grp_dist_arb.sv
// N-channel distributor in front of the ping-pong orbit group buffers.
// Channels share one write/read-back bus owned round-robin; that bus goes
// to bank chBank while the frame former reads the other bank. Banks swap
// on iSwitch edges, optionally deferred until the bus is free.
module grp_dist_arb
  import grp_dist_arb_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int DW        = DEF_DW,
  parameter int AW        = DEF_AW,
  parameter int SWAP_MODE = 1,
  parameter int CW        = DEF_CW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    busy,
  input  logic [N*DW-1:0] wrdOut,
  input  logic [N*AW-1:0] wrdAddr,
  input  logic [N-1:0]    wren,
  input  logic [N*AW-1:0] oldWrdAddr,
  input  logic [N-1:0]    oldRdEn,
  output logic [DW-1:0]   oldWrd,
  output logic [N-1:0]    grant,
  input  logic            iSwitch,
  input  logic [AW-1:0]   ffRdAddr,
  input  logic            ffRdEn,
  output logic [DW-1:0]   ffData,
  output logic [DW-1:0]   memWrData,
  output logic [AW-1:0]   memWrAddr,
  output logic [1:0]      memWrEn,
  output logic [AW-1:0]   memRdAddr0,
  output logic [AW-1:0]   memRdAddr1,
  output logic [1:0]      memRdEn,
  input  logic [DW-1:0]   memRdData0,
  input  logic [DW-1:0]   memRdData1,
  output logic            swapPending,
  output logic [CW-1:0]   dropCnt
);

  localparam int IW = $clog2(N);
  localparam int SW = CW + 4;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  // Arbiter interface
  logic [N-1:0]  grant_s;
  logic [IW-1:0] owner_idx_s;
  logic          owner_vld_s;
  logic          inhibit_s;

  // Bank / swap state
  logic      ch_bank_q, ch_bank_d;
  logic      sw_seen_q, sw_seen_d;
  sw_state_e sw_state_q, sw_state_d;
  logic      sw_edge_s;
  logic      swap_now_s;

  // Drop counter
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [N-1:0]  rej_s;
  logic [3:0]    pop_s;
  logic [SW-1:0] drop_sum_s;

  // Read-back registers
  logic          rd_sel_q, rd_sel_d;
  logic [DW-1:0] old_wrd_q, old_wrd_d;
  logic [DW-1:0] ff_data_q, ff_data_d;

  // Owner bus
  logic [DW-1:0] own_data_s;
  logic [AW-1:0] own_addr_s;
  logic          own_wren_s;
  logic [AW-1:0] own_rdaddr_s;
  logic          own_rden_s;

  rr_arbiter_n #(
    .N  (N),
    .IW (IW)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .busy      (busy),
    .inhibit   (inhibit_s),
    .grant     (grant_s),
    .owner_idx (owner_idx_s),
    .owner_vld (owner_vld_s)
  );

  // Swap control: decide when chBank toggles and track a deferred swap
  always_comb begin
    sw_edge_s  = iSwitch ^ sw_seen_q;
    sw_seen_d  = iSwitch;
    sw_state_d = sw_state_q;
    swap_now_s = 1'b0;
    if (SWAP_MODE == 0) begin
      swap_now_s = sw_edge_s;
      sw_state_d = SW_IDLE;
    end else begin
      case (sw_state_q)
        SW_IDLE: begin
          if (sw_edge_s) begin
            if (!owner_vld_s && (busy == '0)) begin
              swap_now_s = 1'b1;
            end else begin
              sw_state_d = SW_PEND;
            end
          end else begin
            sw_state_d = SW_IDLE;
          end
        end
        SW_PEND: begin
          if (sw_edge_s) begin
            // second edge restores the original bank: drop the swap
            sw_state_d = SW_IDLE;
          end else if (!owner_vld_s) begin
            swap_now_s = 1'b1;
            sw_state_d = SW_IDLE;
          end else begin
            sw_state_d = SW_PEND;
          end
        end
        default: begin
          sw_state_d = SW_IDLE;
        end
      endcase
    end
    ch_bank_d = swap_now_s ? ~ch_bank_q : ch_bank_q;
  end

  // A bank swap takes precedence over a new award in the same cycle
  assign inhibit_s = (SWAP_MODE != 0) && swap_now_s;

  // Saturating count of writes issued by channels without the grant
  always_comb begin
    rej_s      = wren & ~grant_s;
    pop_s      = popcount8(8'(rej_s));
    drop_sum_s = SW'(drop_cnt_q) + SW'(pop_s);
    if (drop_sum_s > SW'(CNT_MAX)) begin
      drop_cnt_d = CNT_MAX;
    end else begin
      drop_cnt_d = drop_sum_s[CW-1:0];
    end
  end

  // Select the owner's write and read-back signals; idle bus drives zeros
  always_comb begin
    own_data_s   = '0;
    own_addr_s   = '0;
    own_wren_s   = 1'b0;
    own_rdaddr_s = '0;
    own_rden_s   = 1'b0;
    if (owner_vld_s) begin
      own_data_s   = wrdOut[int'(owner_idx_s)*DW +: DW];
      own_addr_s   = wrdAddr[int'(owner_idx_s)*AW +: AW];
      own_wren_s   = wren[owner_idx_s];
      own_rdaddr_s = oldWrdAddr[int'(owner_idx_s)*AW +: AW];
      own_rden_s   = oldRdEn[owner_idx_s];
    end else begin
      own_data_s = '0;
    end
  end

  // Route the owner bus to chBank and the frame former to the other bank
  always_comb begin
    memWrData = own_data_s;
    memWrAddr = own_addr_s;
    memWrEn   = 2'b00;
    memRdEn   = 2'b00;
    if (ch_bank_q == BANK1) begin
      memWrEn[1] = own_wren_s & ~reset;
      memRdAddr1 = own_rdaddr_s;
      memRdEn[1] = own_rden_s & ~reset;
      memRdAddr0 = ffRdAddr;
      memRdEn[0] = ffRdEn & ~reset;
    end else begin
      memWrEn[0] = own_wren_s & ~reset;
      memRdAddr0 = own_rdaddr_s;
      memRdEn[0] = own_rden_s & ~reset;
      memRdAddr1 = ffRdAddr;
      memRdEn[1] = ffRdEn & ~reset;
    end
  end

  // Read-back data follows the bank selection captured at request time
  always_comb begin
    rd_sel_d = ch_bank_q;
    if (rd_sel_q == BANK1) begin
      old_wrd_d = memRdData1;
      ff_data_d = memRdData0;
    end else begin
      old_wrd_d = memRdData0;
      ff_data_d = memRdData1;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_bank_q  <= BANK1;
      sw_seen_q  <= 1'b0;
      sw_state_q <= SW_IDLE;
      drop_cnt_q <= '0;
      rd_sel_q   <= BANK1;
      old_wrd_q  <= '0;
      ff_data_q  <= '0;
    end else begin
      ch_bank_q  <= ch_bank_d;
      sw_seen_q  <= sw_seen_d;
      sw_state_q <= sw_state_d;
      drop_cnt_q <= drop_cnt_d;
      rd_sel_q   <= rd_sel_d;
      old_wrd_q  <= old_wrd_d;
      ff_data_q  <= ff_data_d;
    end
  end

  assign grant       = grant_s;
  assign swapPending = (sw_state_q == SW_PEND);
  assign dropCnt     = drop_cnt_q;
  assign oldWrd      = old_wrd_q;
  assign ffData      = ff_data_q;

endmodule

// File: tb/tb_grp_dist_arb.sv
// Directed bench for grp_dist_arb: a deferred-swap instance (u_dut1) with a
// behavioural bank pair, and an immediate-swap instance (u_dut0) on the same
// stimulus.
module tb_grp_dist_arb;

  localparam int N  = 5;
  localparam int DW = 12;
  localparam int AW = 10;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    busy, wren, oldRdEn;
  logic [N*DW-1:0] wrdOut;
  logic [N*AW-1:0] wrdAddr, oldWrdAddr;
  logic            iSwitch, ffRdEn;
  logic [AW-1:0]   ffRdAddr;

  logic [DW-1:0] old_wrd1, ff_data1, wr_data1, bank_rd0, bank_rd1;
  logic [N-1:0]  grant1;
  logic [AW-1:0] wr_addr1, rd_addr0_1, rd_addr1_1;
  logic [1:0]    wr_en1, rd_en1;
  logic          pend1;
  logic [CW-1:0] drop1;

  logic [DW-1:0] old_wrd0, ff_data0, wr_data0;
  logic [N-1:0]  grant0;
  logic [AW-1:0] wr_addr0, rd_addr0_0, rd_addr1_0;
  logic [1:0]    wr_en0, rd_en0;
  logic          pend0;
  logic [CW-1:0] drop0;
  logic [DW-1:0] zero_dw;

  logic [DW-1:0] mem0 [0:1023];
  logic [DW-1:0] mem1 [0:1023];

  int pass_cnt;
  int total_cnt;

  always #5 clk = ~clk;

  assign zero_dw = '0;

  grp_dist_arb #(.N(N), .DW(DW), .AW(AW), .SWAP_MODE(1), .CW(CW)) u_dut1 (
    .clk(clk), .reset(reset), .busy(busy), .wrdOut(wrdOut), .wrdAddr(wrdAddr),
    .wren(wren), .oldWrdAddr(oldWrdAddr), .oldRdEn(oldRdEn), .oldWrd(old_wrd1),
    .grant(grant1), .iSwitch(iSwitch), .ffRdAddr(ffRdAddr), .ffRdEn(ffRdEn),
    .ffData(ff_data1), .memWrData(wr_data1), .memWrAddr(wr_addr1), .memWrEn(wr_en1),
    .memRdAddr0(rd_addr0_1), .memRdAddr1(rd_addr1_1), .memRdEn(rd_en1),
    .memRdData0(bank_rd0), .memRdData1(bank_rd1), .swapPending(pend1), .dropCnt(drop1)
  );

  grp_dist_arb #(.N(N), .DW(DW), .AW(AW), .SWAP_MODE(0), .CW(CW)) u_dut0 (
    .clk(clk), .reset(reset), .busy(busy), .wrdOut(wrdOut), .wrdAddr(wrdAddr),
    .wren(wren), .oldWrdAddr(oldWrdAddr), .oldRdEn(oldRdEn), .oldWrd(old_wrd0),
    .grant(grant0), .iSwitch(iSwitch), .ffRdAddr(ffRdAddr), .ffRdEn(ffRdEn),
    .ffData(ff_data0), .memWrData(wr_data0), .memWrAddr(wr_addr0), .memWrEn(wr_en0),
    .memRdAddr0(rd_addr0_0), .memRdAddr1(rd_addr1_0), .memRdEn(rd_en0),
    .memRdData0(zero_dw), .memRdData1(zero_dw), .swapPending(pend0), .dropCnt(drop0)
  );

  // Behavioural bank pair for u_dut1: synchronous write, one-cycle read latency
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
      bank_rd0 <= '0;
      bank_rd1 <= '0;
    end else begin
      if (wr_en1[0]) mem0[wr_addr1] <= wr_data1;
      if (wr_en1[1]) mem1[wr_addr1] <= wr_data1;
      if (rd_en1[0]) bank_rd0 <= mem0[rd_addr0_1];
      if (rd_en1[1]) bank_rd1 <= mem1[rd_addr1_1];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [DW-1:0] d, input logic [AW-1:0] a);
    wrdOut[k*DW +: DW]     = d;
    wrdAddr[k*AW +: AW]    = a;
    oldWrdAddr[k*AW +: AW] = a;
  endtask

  task automatic test_reset();
    reset = 1'b1; busy = '0; wren = '0; oldRdEn = '0; wrdOut = '0; wrdAddr = '0;
    oldWrdAddr = '0; iSwitch = 1'b0; ffRdEn = 1'b1; ffRdAddr = 10'd5;
    tick(); tick();
    total_cnt++; if (rd_en1 !== 2'b00) $display("FAIL rst_rden_in_reset got=%b exp=%b", rd_en1, 2'b00); else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++; if (grant1 !== 5'b00000) $display("FAIL rst_grant got=%b exp=%b", grant1, 5'b00000); else pass_cnt++;
    total_cnt++; if (drop1 !== 8'd0) $display("FAIL rst_drop got=%0d exp=0", drop1); else pass_cnt++;
    total_cnt++; if (wr_en1 !== 2'b00) $display("FAIL rst_wren got=%b exp=00", wr_en1); else pass_cnt++;
    total_cnt++; if (pend1 !== 1'b0) $display("FAIL rst_pending got=%b exp=0", pend1); else pass_cnt++;
    total_cnt++; if (rd_en1 !== 2'b01) $display("FAIL rst_ff_rden got=%b exp=%b", rd_en1, 2'b01); else pass_cnt++;
    total_cnt++; if (rd_addr0_1 !== 10'd5) $display("FAIL rst_ff_addr got=%0d exp=5", rd_addr0_1); else pass_cnt++;
    total_cnt++; if (old_wrd1 !== 12'h000) $display("FAIL rst_oldwrd got=%h exp=000", old_wrd1); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    busy = 5'b10110;
    tick();
    total_cnt++; if (grant1 !== 5'b00010) $display("FAIL rr_g1 got=%b exp=%b", grant1, 5'b00010); else pass_cnt++;
    busy = 5'b10100;
    tick();
    total_cnt++; if (grant1 !== 5'b00000) $display("FAIL rr_gap1 got=%b exp=%b", grant1, 5'b00000); else pass_cnt++;
    tick();
    total_cnt++; if (grant1 !== 5'b00100) $display("FAIL rr_g2 got=%b exp=%b", grant1, 5'b00100); else pass_cnt++;
    busy = 5'b10010;
    tick();
    total_cnt++; if (grant1 !== 5'b00000) $display("FAIL rr_gap2 got=%b exp=%b", grant1, 5'b00000); else pass_cnt++;
    tick();
    total_cnt++; if (grant1 !== 5'b10000) $display("FAIL rr_g3 got=%b exp=%b", grant1, 5'b10000); else pass_cnt++;
    busy = 5'b00010;
    tick(); tick();
    total_cnt++; if (grant1 !== 5'b00010) $display("FAIL rr_g4 got=%b exp=%b", grant1, 5'b00010); else pass_cnt++;
    busy = 5'b00000;
    tick(); tick();
  endtask

  task automatic test_write_readback();
    busy = 5'b00100;
    tick();
    total_cnt++; if (grant1 !== 5'b00100) $display("FAIL wr_grant got=%b exp=%b", grant1, 5'b00100); else pass_cnt++;
    set_ch(0, 12'h123, 10'h001);
    set_ch(2, 12'hABC, 10'h3FF);
    wren = 5'b00100;
    #1;
    total_cnt++; if (wr_en1 !== 2'b10) $display("FAIL wr_en got=%b exp=%b", wr_en1, 2'b10); else pass_cnt++;
    total_cnt++; if (wr_data1 !== 12'hABC) $display("FAIL wr_data got=%h exp=abc", wr_data1); else pass_cnt++;
    total_cnt++; if (wr_addr1 !== 10'h3FF) $display("FAIL wr_addr got=%h exp=3ff", wr_addr1); else pass_cnt++;
    tick();
    wren = '0;
    oldRdEn = 5'b00100;
    #1;
    total_cnt++; if (rd_en1 !== 2'b11) $display("FAIL rb_rden got=%b exp=%b", rd_en1, 2'b11); else pass_cnt++;
    total_cnt++; if (rd_addr1_1 !== 10'h3FF) $display("FAIL rb_addr got=%h exp=3ff", rd_addr1_1); else pass_cnt++;
    tick();
    oldRdEn = '0;
    tick();
    total_cnt++; if (old_wrd1 !== 12'hABC) $display("FAIL rb_data got=%h exp=abc", old_wrd1); else pass_cnt++;
    total_cnt++; if (drop1 !== 8'd0) $display("FAIL wr_nodrop got=%0d exp=0", drop1); else pass_cnt++;
  endtask

  task automatic test_drop_saturate();
    int bad;
    bad = 0;
    wren = 5'b01001;
    #1;
    total_cnt++; if (wr_en1 !== 2'b00) $display("FAIL drop_nowrite got=%b exp=00", wr_en1); else pass_cnt++;
    tick();
    total_cnt++; if (drop1 !== 8'd2) $display("FAIL drop_pop got=%0d exp=2", drop1); else pass_cnt++;
    wren = 5'b00001;
    for (int i = 0; i < 298; i++) begin
      if (wr_en1 !== 2'b00) bad++;
      tick();
    end
    total_cnt++; if (bad !== 0) $display("FAIL drop_write_cycles got=%0d exp=0", bad); else pass_cnt++;
    total_cnt++; if (drop1 !== 8'd255) $display("FAIL drop_sat got=%0d exp=255", drop1); else pass_cnt++;
    wren = '0;
    busy = '0;
    tick(); tick();
  endtask

  task automatic test_swap_deferred();
    busy = 5'b00100;
    tick();
    total_cnt++; if (grant1 !== 5'b00100) $display("FAIL sw_grant got=%b exp=%b", grant1, 5'b00100); else pass_cnt++;
    iSwitch = 1'b1;
    tick();
    total_cnt++; if (pend1 !== 1'b1) $display("FAIL sw_pend_set got=%b exp=1", pend1); else pass_cnt++;
    total_cnt++; if (rd_en1 !== 2'b01) $display("FAIL sw_bank_held got=%b exp=01", rd_en1); else pass_cnt++;
    tick();
    busy = 5'b01000;
    tick();
    total_cnt++; if (grant1 !== 5'b00000) $display("FAIL sw_release got=%b exp=%b", grant1, 5'b00000); else pass_cnt++;
    total_cnt++; if (pend1 !== 1'b1) $display("FAIL sw_pend_hold got=%b exp=1", pend1); else pass_cnt++;
    tick();
    total_cnt++; if (rd_en1 !== 2'b10) $display("FAIL sw_bank_toggled got=%b exp=10", rd_en1); else pass_cnt++;
    total_cnt++; if (pend1 !== 1'b0) $display("FAIL sw_pend_clr got=%b exp=0", pend1); else pass_cnt++;
    total_cnt++; if (grant1 !== 5'b00000) $display("FAIL sw_wins got=%b exp=%b", grant1, 5'b00000); else pass_cnt++;
    tick();
    total_cnt++; if (grant1 !== 5'b01000) $display("FAIL sw_regrant got=%b exp=%b", grant1, 5'b01000); else pass_cnt++;
  endtask

  task automatic test_swap_cancel();
    iSwitch = 1'b0;
    tick();
    total_cnt++; if (pend1 !== 1'b1) $display("FAIL cx_pend_set got=%b exp=1", pend1); else pass_cnt++;
    iSwitch = 1'b1;
    tick();
    total_cnt++; if (pend1 !== 1'b0) $display("FAIL cx_pend_clr got=%b exp=0", pend1); else pass_cnt++;
    busy = '0;
    tick(); tick();
    total_cnt++; if (rd_en1 !== 2'b10) $display("FAIL cx_no_swap got=%b exp=10", rd_en1); else pass_cnt++;
    ffRdAddr = 10'h3FF;
    tick(); tick();
    total_cnt++; if (ff_data1 !== 12'hABC) $display("FAIL cx_ffdata got=%h exp=abc", ff_data1); else pass_cnt++;
  endtask

  task automatic test_swap_immediate();
    total_cnt++; if (rd_en0 !== 2'b10) $display("FAIL im_bank_start got=%b exp=10", rd_en0); else pass_cnt++;
    busy = 5'b00100;
    set_ch(2, 12'h5A5, 10'h010);
    wren = 5'b00100;
    tick();
    total_cnt++; if (grant0 !== 5'b00100) $display("FAIL im_grant got=%b exp=%b", grant0, 5'b00100); else pass_cnt++;
    total_cnt++; if (wr_en0 !== 2'b01) $display("FAIL im_wr_old got=%b exp=01", wr_en0); else pass_cnt++;
    iSwitch = 1'b0;
    tick();
    total_cnt++; if (wr_en0 !== 2'b10) $display("FAIL im_wr_new got=%b exp=10", wr_en0); else pass_cnt++;
    total_cnt++; if (pend0 !== 1'b0) $display("FAIL im_pend got=%b exp=0", pend0); else pass_cnt++;
    wren = '0;
    busy = '0;
    tick();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_round_robin();
    test_write_readback();
    test_drop_saturate();
    test_swap_deferred();
    test_swap_cancel();
    test_swap_immediate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
